// File: rtl/cpu_seq_pkg.sv
// Shared constants and types for the instruction sequencer: class codes,
// instruction field layout and the sequencer state encoding.
package cpu_seq_pkg;

  // Instruction class codes
  typedef enum logic [1:0] {
    CLS_ALU   = 2'b00,
    CLS_LOADI = 2'b01,
    CLS_CMP   = 2'b10,
    CLS_HALT  = 2'b11
  } cls_e;

  // Field widths independent of the datapath parameters
  localparam int CLS_W   = 2;
  localparam int COMM_W  = 4;
  localparam int FLAGS_W = 3;
  localparam int CTRL_W  = CLS_W + COMM_W + 3;

  // Offsets of the control bits above the {rd, ra, rb, imm} block
  localparam int BSEL_OFS = 0;
  localparam int CIN_OFS  = 1;
  localparam int MODE_OFS = 2;
  localparam int COMM_OFS = 3;
  localparam int CLS_OFS  = 7;

  // Absolute field positions for the default layout (16-bit data, 8 registers)
  localparam int CLS_MSB  = 33;
  localparam int CLS_LSB  = 32;
  localparam int COMM_MSB = 31;
  localparam int COMM_LSB = 28;
  localparam int MODE_BIT = 27;
  localparam int CIN_BIT  = 26;
  localparam int BSEL_BIT = 25;
  localparam int RD_MSB   = 24;
  localparam int RD_LSB   = 22;
  localparam int RA_MSB   = 21;
  localparam int RA_LSB   = 19;
  localparam int RB_MSB   = 18;
  localparam int RB_LSB   = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  // Instruction word width for a given datapath configuration
  function automatic int instr_width(input int data_width, input int addr_width);
    return CTRL_W + 3 * addr_width + data_width;
  endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational split of the instruction register into its fields.
module cpu_seq_decode
  import cpu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int IW         = CTRL_W + 3 * ADDR_WIDTH + DATA_WIDTH
) (
  input  logic [IW-1:0]         i_ir,
  output logic [CLS_W-1:0]      o_cls,
  output logic [COMM_W-1:0]     o_comm,
  output logic                  o_mode,
  output logic                  o_cin,
  output logic                  o_bsel,
  output logic [ADDR_WIDTH-1:0] o_rd,
  output logic [ADDR_WIDTH-1:0] o_ra,
  output logic [ADDR_WIDTH-1:0] o_rb,
  output logic [DATA_WIDTH-1:0] o_imm
);

  localparam int RB_POS   = DATA_WIDTH;
  localparam int RA_POS   = RB_POS + ADDR_WIDTH;
  localparam int RD_POS   = RA_POS + ADDR_WIDTH;
  localparam int CTRL_POS = RD_POS + ADDR_WIDTH;

  // Field extraction: pure wiring, no state
  always_comb begin
    o_imm  = i_ir[DATA_WIDTH-1:0];
    o_rb   = i_ir[RB_POS +: ADDR_WIDTH];
    o_ra   = i_ir[RA_POS +: ADDR_WIDTH];
    o_rd   = i_ir[RD_POS +: ADDR_WIDTH];
    o_bsel = i_ir[CTRL_POS + BSEL_OFS];
    o_cin  = i_ir[CTRL_POS + CIN_OFS];
    o_mode = i_ir[CTRL_POS + MODE_OFS];
    o_comm = i_ir[CTRL_POS + COMM_OFS +: COMM_W];
    o_cls  = i_ir[CTRL_POS + CLS_OFS +: CLS_W];
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches instructions over a req/valid handshake,
// drives the regfile/ALU datapath controls, writes results back and latches
// the ALU flags. Runs from start until a HALT instruction.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REGS     = 8,
  parameter int PC_WIDTH     = 8,
  localparam int ADDR_WIDTH  = $clog2(NUM_REGS),
  localparam int IW          = CTRL_W + 3 * ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  // instruction memory
  output logic                  o_imem_req,
  output logic [PC_WIDTH-1:0]   o_imem_addr,
  input  logic                  i_imem_valid,
  input  logic [IW-1:0]         i_imem_rdata,
  // datapath controls
  output logic                  o_reg_write_enable,
  output logic [ADDR_WIDTH-1:0] o_reg_write_addr,
  output logic [DATA_WIDTH-1:0] o_reg_write_data,
  output logic [ADDR_WIDTH-1:0] o_reg_read_addr1,
  output logic [ADDR_WIDTH-1:0] o_reg_read_addr2,
  output logic [COMM_W-1:0]     o_alu_comm,
  output logic                  o_alu_mode,
  output logic                  o_alu_cin,
  output logic                  o_b_source_sel,
  output logic [DATA_WIDTH-1:0] o_alu_b_imm,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_alu_cout,
  input  logic                  i_alu_nbo,
  input  logic                  i_alu_ngo,
  // status
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic [FLAGS_W-1:0]    o_flags,
  output logic                  o_busy,
  output logic                  o_halted
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e                  r_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [IW-1:0]           r_ir;
  logic [FLAGS_W-1:0]      r_flags;
  logic [DATA_WIDTH-1:0]   r_wb_data;
  logic [ADDR_WIDTH-1:0]   r_wb_addr;
  logic                    r_we;
  logic                    r_req;
  logic                    r_busy;
  logic                    r_halted;

  logic [CLS_W-1:0]        w_cls;
  logic [COMM_W-1:0]       w_comm;
  logic                    w_mode;
  logic                    w_cin;
  logic                    w_bsel;
  logic [ADDR_WIDTH-1:0]   w_rd;
  logic [ADDR_WIDTH-1:0]   w_ra;
  logic [ADDR_WIDTH-1:0]   w_rb;
  logic [DATA_WIDTH-1:0]   w_imm;
  logic [CLS_W-1:0]        w_fetch_cls;
  logic                    w_flag_op;

  cpu_seq_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IW         (IW)
  ) u_decode (
    .i_ir   (r_ir),
    .o_cls  (w_cls),
    .o_comm (w_comm),
    .o_mode (w_mode),
    .o_cin  (w_cin),
    .o_bsel (w_bsel),
    .o_rd   (w_rd),
    .o_ra   (w_ra),
    .o_rb   (w_rb),
    .o_imm  (w_imm)
  );

  // The HALT decision is taken on the incoming word, before it reaches the IR
  assign w_fetch_cls = i_imem_rdata[IW-1 -: CLS_W];
  assign w_flag_op   = (w_cls == CLS_ALU) || (w_cls == CLS_CMP);

  // Sequencer FSM with pc, IR, write-back and flag registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_flags   <= '0;
      r_wb_data <= '0;
      r_wb_addr <= '0;
      r_we      <= 1'b0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (i_imem_valid) begin
            r_ir  <= i_imem_rdata;
            r_req <= 1'b0;
            if (w_fetch_cls == CLS_HALT) begin
              // pc stays on the HALT address
              r_state  <= S_HALTED;
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // ALU outputs have settled from the IR-driven controls by now
          if (w_flag_op) begin
            r_flags <= {i_alu_cout, i_alu_nbo, i_alu_ngo};
          end
          if (w_cls == CLS_CMP) begin
            r_pc    <= r_pc + PC_ONE;
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_wb_data <= (w_cls == CLS_ALU) ? i_alu_result : w_imm;
            r_wb_addr <= w_rd;
            r_we      <= 1'b1;
            r_state   <= S_WB;
          end
        end
        S_WB: begin
          r_we    <= 1'b0;
          r_pc    <= r_pc + PC_ONE;
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_HALTED: begin
          if (i_start) begin
            r_pc     <= '0;
            r_flags  <= '0;
            r_state  <= S_FETCH;
            r_req    <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  // ALU controls come straight from the IR so they stay stable from EXEC through WB
  always_comb begin
    o_reg_read_addr1 = w_ra;
    o_reg_read_addr2 = w_rb;
    o_alu_comm       = w_comm;
    o_alu_mode       = w_mode;
    o_alu_cin        = w_cin;
    o_b_source_sel   = w_bsel;
    o_alu_b_imm      = w_imm;
  end

  // Registered status and handshake outputs
  always_comb begin
    o_imem_req         = r_req;
    o_imem_addr        = r_pc;
    o_reg_write_enable = r_we;
    o_reg_write_addr   = r_wb_addr;
    o_reg_write_data   = r_wb_data;
    o_pc               = r_pc;
    o_flags            = r_flags;
    o_busy             = r_busy;
    o_halted           = r_halted;
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: behavioural regfile + 74181 datapath and ROM,
// table vectors from worked examples, random programs against an ISA-level
// interpreter, and hand sequences for wait states, reset and pc wrap.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // DUT wiring
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr, pc;
  logic [33:0] imem_rdata;
  logic        we, mode, cin, bsel, cout, nbo, ngo, busy, halted;
  logic [2:0]  wa, ra, rb, flags;
  logic [15:0] wd, imm, alu_result;
  logic [3:0]  comm;

  // second instance: 2-bit pc, fed LOADI r0=0 forever
  logic        req2, we2, mode2, cin2, bsel2, busy2, halted2;
  logic [1:0]  addr2, pc2;
  logic [2:0]  wa2, ra2, rb2, flags2;
  logic [15:0] wd2, imm2;
  logic [3:0]  comm2;
  logic [33:0] rdata2;
  assign rdata2 = 34'h1_0000_0000;

  cpu_sequencer u_dut (
    .i_clk (clk), .i_reset_n (rst_n), .i_start (start),
    .o_imem_req (imem_req), .o_imem_addr (imem_addr),
    .i_imem_valid (imem_valid), .i_imem_rdata (imem_rdata),
    .o_reg_write_enable (we), .o_reg_write_addr (wa), .o_reg_write_data (wd),
    .o_reg_read_addr1 (ra), .o_reg_read_addr2 (rb),
    .o_alu_comm (comm), .o_alu_mode (mode), .o_alu_cin (cin),
    .o_b_source_sel (bsel), .o_alu_b_imm (imm),
    .i_alu_result (alu_result), .i_alu_cout (cout), .i_alu_nbo (nbo), .i_alu_ngo (ngo),
    .o_pc (pc), .o_flags (flags), .o_busy (busy), .o_halted (halted)
  );

  cpu_sequencer #(.PC_WIDTH(2)) u_wrap (
    .i_clk (clk), .i_reset_n (rst_n), .i_start (start2),
    .o_imem_req (req2), .o_imem_addr (addr2),
    .i_imem_valid (req2), .i_imem_rdata (rdata2),
    .o_reg_write_enable (we2), .o_reg_write_addr (wa2), .o_reg_write_data (wd2),
    .o_reg_read_addr1 (ra2), .o_reg_read_addr2 (rb2),
    .o_alu_comm (comm2), .o_alu_mode (mode2), .o_alu_cin (cin2),
    .o_b_source_sel (bsel2), .o_alu_b_imm (imm2),
    .i_alu_result (16'h0000), .i_alu_cout (1'b0), .i_alu_nbo (1'b1), .i_alu_ngo (1'b1),
    .o_pc (pc2), .o_flags (flags2), .o_busy (busy2), .o_halted (halted2)
  );

  // 74181 behaviour, active-high data: returns {cout, nbo, ngo, F}
  function automatic logic [18:0] alu_f(input logic [3:0] s, input logic m, input logic ci,
                                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [16:0] g, t;
    x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    g = {1'b0, x} + {1'b0, y};
    t = g + {16'd0, ~ci};
    if (m) return {1'b0, ~&(x ^ y), ~g[16], ~(x ^ y)};
    return {t[16], ~&(x ^ y), ~g[16], t[15:0]};
  endfunction

  function automatic logic [33:0] mk(input logic [1:0] c, input logic [3:0] s, input logic m,
                                     input logic ci, input logic bs, input logic [2:0] rd,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [15:0] im);
    return {c, s, m, ci, bs, rd, a, b, im};
  endfunction

  // Datapath model: register file and ALU
  logic [15:0] rf [8];
  logic [15:0] rf_init [8];
  logic        rf_load = 1'b0;
  int          n_writes = 0;
  logic [18:0] alu_out;

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (we) begin
      rf[wa] <= wd;
    end
    if (we) n_writes <= n_writes + 1;
  end

  always_comb alu_out = alu_f(comm, mode, cin, rf[ra], bsel ? imm : rf[rb]);
  assign alu_result = alu_out[15:0];
  assign cout = alu_out[18];
  assign nbo  = alu_out[17];
  assign ngo  = alu_out[16];

  // ROM with programmable wait states
  logic [33:0] rom [256];
  int n_wait = 0;
  int wcnt = 0;
  assign imem_valid = imem_req && (wcnt == n_wait);
  assign imem_rdata = rom[imem_addr];
  always @(posedge clk) begin
    if (!imem_req || imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // While a fetch is pending, req must stay high and the address must not move
  logic       p_req = 1'b0, p_valid = 1'b0;
  logic [7:0] p_addr = '0;
  int         stab_err = 0;
  always @(negedge clk) begin
    if (p_req && !p_valid && !(imem_req === 1'b1 && imem_addr === p_addr))
      stab_err <= stab_err + 1;
    p_req   <= imem_req;
    p_valid <= imem_valid;
    p_addr  <= imem_addr;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load_rf();
    @(negedge clk); rf_load = 1'b1;
    @(negedge clk); rf_load = 1'b0;
  endtask

  // Pulse start and count cycles until halted (bounded)
  task automatic run(input int nw, input int limit, output int cyc);
    n_wait = nw;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (halted !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ISA-level reference: executes rom from address 0 until HALT
  logic [15:0] m_rf [8];
  logic [2:0]  m_flags;
  int          m_pc, m_cyc, m_wr;

  task automatic model_run(input int nw);
    logic [33:0] w;
    logic [18:0] r;
    logic [15:0] b;
    m_pc = 0; m_flags = 3'b000; m_cyc = 0; m_wr = 0;
    for (int k = 0; k < 256; k++) begin
      w = rom[m_pc];
      m_cyc += 1 + nw;
      if (w[33:32] == 2'b11) break;
      b = w[25] ? w[15:0] : m_rf[w[18:16]];
      r = alu_f(w[31:28], w[27], w[26], m_rf[w[21:19]], b);
      case (w[33:32])
        2'b00: begin m_rf[w[24:22]] = r[15:0]; m_flags = r[18:16]; m_cyc += 2; m_wr++; end
        2'b01: begin m_rf[w[24:22]] = w[15:0]; m_cyc += 2; m_wr++; end
        default: begin m_flags = r[18:16]; m_cyc += 1; end
      endcase
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  typedef struct {
    logic [3:0][33:0] prog;
    int               rd;
    logic [15:0]      val;
    logic [2:0]       flg;
    int               pc;
    int               cycles;
    int               writes;
  } vec_t;

  vec_t        vecs [3];
  logic [33:0] halt_w;
  int          cyc, cnt, w0, nprog, nw;
  logic [15:0] v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    halt_w = mk(2'b11, 4'h0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000);
    vecs[0].prog[0] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 16'h1234);
    vecs[0].prog[1] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 16'h5678);
    vecs[0].prog[2] = mk(2'b00, 4'b1001, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 3'd2, 16'h0000);
    vecs[0].prog[3] = halt_w;
    vecs[0].rd = 3; vecs[0].val = 16'h68AD; vecs[0].flg = 3'b011;
    vecs[0].pc = 3; vecs[0].cycles = 10; vecs[0].writes = 3;
    vecs[1].prog[0] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 16'h1234);
    vecs[1].prog[1] = mk(2'b00, 4'b1011, 1'b1, 1'b0, 1'b1, 3'd4, 3'd1, 3'd0, 16'h00FF);
    vecs[1].prog[2] = halt_w;
    vecs[1].prog[3] = halt_w;
    vecs[1].rd = 4; vecs[1].val = 16'h0034; vecs[1].flg = 3'b010;
    vecs[1].pc = 2; vecs[1].cycles = 7; vecs[1].writes = 2;
    vecs[2].prog[0] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 3'd0, 16'hFFFF);
    vecs[2].prog[1] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 3'd0, 16'h0000);
    vecs[2].prog[2] = mk(2'b10, 4'b1001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 3'd6, 16'h0000);
    vecs[2].prog[3] = halt_w;
    vecs[2].rd = 5; vecs[2].val = 16'hFFFF; vecs[2].flg = 3'b101;
    vecs[2].pc = 3; vecs[2].cycles = 9; vecs[2].writes = 2;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_busy_halted", 32'({busy, halted}), 32'd0);
    chk("rst_pc_flags", 32'({pc, flags}), 32'd0);
    chk("rst_ctrl", 32'({comm, mode, cin, bsel, ra, rb}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Worked examples
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
      load_rf();
      for (int i = 0; i < 4; i++) rom[i] = vecs[t].prog[i];
      w0 = n_writes;
      run(0, 200, cyc);
      chk($sformatf("vec%0d_halted", t), 32'(halted), 32'd1);
      chk($sformatf("vec%0d_reg", t), 32'(rf[vecs[t].rd]), 32'(vecs[t].val));
      chk($sformatf("vec%0d_flags", t), 32'(flags), 32'(vecs[t].flg));
      chk($sformatf("vec%0d_pc", t), 32'(pc), 32'(vecs[t].pc));
      chk($sformatf("vec%0d_cycles", t), 32'(cyc), 32'(vecs[t].cycles));
      chk($sformatf("vec%0d_writes", t), 32'(n_writes - w0), 32'(vecs[t].writes));
    end

    // Three wait states per fetch: same result, 3 extra cycles per instruction
    for (int i = 0; i < 8; i++) rf_init[i] = 16'h0000;
    load_rf();
    for (int i = 0; i < 4; i++) rom[i] = vecs[0].prog[i];
    run(3, 200, cyc);
    chk("wait_r3", 32'(rf[3]), 32'h68AD);
    chk("wait_cycles", 32'(cyc), 32'd22);
    chk("wait_pc", 32'(pc), 32'd3);

    // start pulsed mid-run must be ignored
    n_wait = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    repeat (4) begin @(negedge clk); cnt++; end
    start = 1'b1;
    @(negedge clk); cnt++;
    start = 1'b0;
    while (halted !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("busy_start_cycles", 32'(cnt), 32'd10);
    chk("busy_start_pc", 32'(pc), 32'd3);
    chk("busy_start_flags", 32'(flags), 32'd3);

    // start in HALTED restarts at pc 0 with flags cleared
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_flags", 32'(flags), 32'd0);
    chk("restart_busy", 32'({busy, halted}), 32'b10);
    cnt = 0;
    while (halted !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("restart_done", 32'(halted), 32'd1);

    // Random programs against the reference interpreter
    for (int p = 0; p < 16; p++) begin
      nprog = $urandom_range(3, 12);
      nw = $urandom_range(0, 2);
      for (int i = 0; i < nprog; i++)
        rom[i] = mk(2'($urandom_range(0, 2)), 4'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      rom[nprog] = mk(2'b11, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
      for (int i = 0; i < 8; i++) begin
        v = 16'($urandom);
        rf_init[i] = v;
        m_rf[i] = v;
      end
      load_rf();
      model_run(nw);
      w0 = n_writes;
      run(nw, 400, cyc);
      chk($sformatf("rnd%0d_halted", p), 32'(halted), 32'd1);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd%0d_r%0d", p, i), 32'(rf[i]), 32'(m_rf[i]));
      chk($sformatf("rnd%0d_flags", p), 32'(flags), 32'(m_flags));
      chk($sformatf("rnd%0d_pc", p), 32'(pc), 32'(m_pc));
      chk($sformatf("rnd%0d_cycles", p), 32'(cyc), 32'(m_cyc));
      chk($sformatf("rnd%0d_writes", p), 32'(n_writes - w0), 32'(m_wr));
    end

    // Reset asserted during WB: write suppressed, back to IDLE with pc 0
    for (int i = 0; i < 8; i++) rf_init[i] = 16'h1111;
    load_rf();
    rom[0] = mk(2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 16'hBEEF);
    rom[1] = halt_w;
    n_wait = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (we !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("wb_reached", 32'(we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_we_drop", 32'(we), 32'd0);
    @(negedge clk);
    chk("rst_no_write", 32'(rf[2]), 32'h1111);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_pc0", 32'(pc), 32'd0);
    chk("rst_idle", 32'({busy, halted, imem_req}), 32'd0);

    // 2-bit pc with no HALT wraps 3 -> 0
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    repeat (9) @(negedge clk);
    chk("wrap_pc3", 32'(pc2), 32'd3);
    repeat (3) @(negedge clk);
    chk("wrap_pc0", 32'(pc2), 32'd0);
    chk("wrap_busy", 32'({busy2, halted2}), 32'b10);

    chk("fetch_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
